bme_frame_assembler: RTL and testbench

Downstream consumer of the SPI sensor reader. Takes the byte stream produced by a burst read of the sensor's data registers (0xF7..0xFC) and reassembles the 20-bit raw pressure and temperature words. It keeps a 4-frame running average of temperature and drives a hysteresis over-temperature alarm. It sits between the SPI reader's byte output and the display/control logic.

---
 rtl/bme_pkg.sv | 34 +++
 rtl/avg4_filter.sv | 54 +++++
 rtl/bme_frame_assembler.sv | 139 +++++++++++++
 tb/tb_bme_frame_assembler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/bme_pkg.sv
// Shared constants and types for the BME sensor frame assembler.
// Byte indices follow the burst-read order of registers 0xF7..0xFC.
package bme_pkg;

    localparam int RAW_W     = 20;
    localparam int SUM_W     = RAW_W + 2;
    localparam int AVG_DEPTH = 4;
    localparam int FRAME_LEN = 6;

    localparam logic [2:0] IDX_P_MSB  = 3'd0;
    localparam logic [2:0] IDX_P_LSB  = 3'd1;
    localparam logic [2:0] IDX_P_XLSB = 3'd2;
    localparam logic [2:0] IDX_T_MSB  = 3'd3;
    localparam logic [2:0] IDX_T_LSB  = 3'd4;
    localparam logic [2:0] IDX_T_XLSB = 3'd5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_PUBLISH = 3'd2;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        PUBLISH = ST_PUBLISH
    } state_t;

    // Only the upper nibble of an XLSB register carries data.
    function automatic logic [RAW_W-1:0] pack_raw(input logic [7:0] msb,
                                                  input logic [7:0] lsb,
                                                  input logic [3:0] xlsb_hi);
        return {msb, lsb, xlsb_hi};
    endfunction

endpackage

// File: rtl/avg4_filter.sv
// Four-sample moving average of the raw temperature word.
// Keeps a running sum so each update is one add and one subtract.
module avg4_filter
    import bme_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [RAW_W-1:0] sample,
    input  logic             sample_valid,
    output logic [RAW_W-1:0] avg_temp,
    output logic             avg_valid
);

    logic [RAW_W-1:0] hist [AVG_DEPTH];
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [2:0]       fill;

    // Sum after the oldest sample is replaced by the incoming one.
    always_comb begin
        sum_next = sum + SUM_W'(sample) - SUM_W'(hist[AVG_DEPTH-1]);
    end

    // Shift history, update sum, and publish once the window is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum       <= '0;
            fill      <= '0;
            avg_temp  <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (sample_valid) begin
                hist[0] <= sample;
                for (int i = 1; i < AVG_DEPTH; i++) begin
                    hist[i] <= hist[i-1];
                end
                sum <= sum_next;
                if (fill != 3'(AVG_DEPTH)) begin
                    fill <= fill + 3'd1;
                end
                // This sample completes (or slides) a full window.
                if (fill >= 3'(AVG_DEPTH - 1)) begin
                    avg_valid <= 1'b1;
                    avg_temp  <= sum_next[SUM_W-1:2];
                end
            end
        end
    end

endmodule

// File: rtl/bme_frame_assembler.sv
// Reassembles 20-bit pressure/temperature words from the SPI burst byte
// stream, averages temperature and raises a hysteresis over-temp alarm.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for frame_start; stray bytes ignored
// COLLECT | storing bytes 0..5, inter-byte watchdog running
// PUBLISH | one cycle: raw words valid, frame_valid high
module bme_frame_assembler
    import bme_pkg::*;
#(
    parameter int               TIMEOUT    = 1000,
    parameter logic [RAW_W-1:0] TEMP_LIMIT = 20'h80000,
    parameter logic [RAW_W-1:0] TEMP_HYST  = 20'h00400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             frame_start,
    output logic [RAW_W-1:0] press_raw,
    output logic [RAW_W-1:0] temp_raw,
    output logic             frame_valid,
    output logic [RAW_W-1:0] avg_temp,
    output logic             avg_valid,
    output logic             temp_alarm,
    output logic             frame_err
);

    localparam int               WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [RAW_W-1:0] TEMP_CLEAR = TEMP_LIMIT - TEMP_HYST;

    state_t          state;
    logic [2:0]      idx;
    logic [7:0]      byte_buf [FRAME_LEN-1];
    logic [WD_W-1:0] wd_cnt;

    // Frame collection FSM with watchdog; outputs are registered so the
    // raw words and frame_valid appear together in the PUBLISH cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            wd_cnt      <= '0;
            press_raw   <= '0;
            temp_raw    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
                byte_buf[i] <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (frame_start) begin
                // A restart over a partial frame throws that frame away.
                if (state == COLLECT && idx != IDX_P_MSB) begin
                    frame_err <= 1'b1;
                end
                if (byte_valid) begin
                    byte_buf[IDX_P_MSB] <= byte_in;
                    idx                 <= IDX_P_LSB;
                end else begin
                    idx <= IDX_P_MSB;
                end
                wd_cnt <= '0;
                state  <= COLLECT;
            end else begin
                case (state)
                    IDLE: begin
                        idx    <= IDX_P_MSB;
                        wd_cnt <= '0;
                    end
                    COLLECT: begin
                        if (byte_valid) begin
                            wd_cnt <= '0;
                            if (idx == IDX_T_XLSB) begin
                                press_raw <= pack_raw(byte_buf[IDX_P_MSB],
                                                      byte_buf[IDX_P_LSB],
                                                      byte_buf[IDX_P_XLSB][7:4]);
                                temp_raw  <= pack_raw(byte_buf[IDX_T_MSB],
                                                      byte_buf[IDX_T_LSB],
                                                      byte_in[7:4]);
                                frame_valid <= 1'b1;
                                idx         <= IDX_P_MSB;
                                state       <= PUBLISH;
                            end else begin
                                byte_buf[idx] <= byte_in;
                                idx           <= idx + 3'd1;
                            end
                        end else if (wd_cnt == WD_LAST) begin
                            frame_err <= 1'b1;
                            idx       <= IDX_P_MSB;
                            wd_cnt    <= '0;
                            state     <= IDLE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    PUBLISH: begin
                        // No room for a byte while the words are published.
                        if (byte_valid) begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: begin
                        idx   <= IDX_P_MSB;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    avg4_filter u_avg4_filter (
        .clk          (clk),
        .reset        (reset),
        .sample       (temp_raw),
        .sample_valid (frame_valid),
        .avg_temp     (avg_temp),
        .avg_valid    (avg_valid)
    );

    // Hysteresis alarm, re-evaluated only when a fresh average arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_alarm <= 1'b0;
        end else if (avg_valid) begin
            if (avg_temp > TEMP_LIMIT) begin
                temp_alarm <= 1'b1;
            end else if (avg_temp < TEMP_CLEAR) begin
                temp_alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bme_frame_assembler.sv
// Directed bench for the frame assembler: framing, averaging, abort,
// watchdog, alarm hysteresis and asynchronous reset.
module tb_bme_frame_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        frame_start;
    logic [19:0] press_raw;
    logic [19:0] temp_raw;
    logic        frame_valid;
    logic [19:0] avg_temp;
    logic        avg_valid;
    logic        temp_alarm;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int fv_cnt = 0, err_cnt = 0, avg_cnt = 0;
    int f0, e0, a0, k;

    bme_frame_assembler #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .press_raw   (press_raw),
        .temp_raw    (temp_raw),
        .frame_valid (frame_valid),
        .avg_temp    (avg_temp),
        .avg_valid   (avg_valid),
        .temp_alarm  (temp_alarm),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (frame_valid) fv_cnt++;
        if (frame_err)   err_cnt++;
        if (avg_valid)   avg_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of stimulus, applied at a falling edge.
    task automatic step(input logic fs, input logic bv, input logic [7:0] b);
        frame_start = fs;
        byte_valid  = bv;
        byte_in     = b;
        @(negedge clk);
        frame_start = 1'b0;
        byte_valid  = 1'b0;
        byte_in     = 8'h00;
    endtask

    // Ends in the cycle after the sixth byte (frame_valid expected high).
    task automatic send_frame(input logic [19:0] p, input logic [19:0] t);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, p[19:12]);
        step(1'b0, 1'b1, p[11:4]);
        step(1'b0, 1'b1, {p[3:0], 4'h5});
        step(1'b0, 1'b1, t[19:12]);
        step(1'b0, 1'b1, t[11:4]);
        step(1'b0, 1'b1, {t[3:0], 4'hA});
    endtask

    task automatic frame_settle(input logic [19:0] p, input logic [19:0] t);
        send_frame(p, t);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_start = 1'b0;
        #2;
        chk("rst_press", press_raw, 0);
        chk("rst_temp", temp_raw, 0);
        chk("rst_avg", avg_temp, 0);
        chk("rst_flags", {frame_valid, avg_valid, temp_alarm, frame_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic frame, plus a byte arriving during PUBLISH.
        f0 = fv_cnt; e0 = err_cnt;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h65);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 8'hC0);
        step(1'b0, 1'b1, 8'h7E);
        step(1'b0, 1'b1, 8'hED);
        chk("basic_fv_early", frame_valid, 0);
        step(1'b0, 1'b1, 8'h00);
        chk("basic_fv", frame_valid, 1);
        chk("basic_press", press_raw, 20'h655AC);
        chk("basic_temp", temp_raw, 20'h7EED0);
        step(1'b0, 1'b1, 8'hFF);
        chk("basic_fv_once", frame_valid, 0);
        step(1'b0, 1'b0, 8'h00);
        chk("basic_fv_cnt", fv_cnt - f0, 1);
        chk("publish_drop_err", err_cnt - e0, 1);
        chk("basic_press_hold", press_raw, 20'h655AC);

        // Restart over a partial frame.
        f0 = fv_cnt; e0 = err_cnt;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        send_frame(20'h12345, 20'h6789A);
        chk("abort_press", press_raw, 20'h12345);
        chk("abort_temp", temp_raw, 20'h6789A);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("abort_err_cnt", err_cnt - e0, 1);
        chk("abort_fv_cnt", fv_cnt - f0, 1);

        // Watchdog: 16 silent cycles abort the frame.
        f0 = fv_cnt; e0 = err_cnt;
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hAB);
        step(1'b0, 1'b1, 8'hCD);
        k = 0;
        while (!frame_err && k < 40) begin
            step(1'b0, 1'b0, 8'h00);
            k++;
        end
        chk("timeout_cycles", k, 16);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h99);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("timeout_err_cnt", err_cnt - e0, 1);
        chk("timeout_no_fv", fv_cnt - f0, 0);
        chk("timeout_press_hold", press_raw, 20'h12345);

        // Averaging from an empty history.
        do_reset();
        a0 = avg_cnt;
        send_frame(20'h00001, 20'h00010);
        send_frame(20'h00002, 20'h00020);
        send_frame(20'h00003, 20'h00030);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("avg_suppressed", avg_cnt - a0, 0);
        send_frame(20'h00004, 20'h00041);
        step(1'b0, 1'b0, 8'h00);
        chk("avg_valid_first", avg_valid, 1);
        chk("avg_4", avg_temp, 20'h00028);
        step(1'b0, 1'b0, 8'h00);
        chk("avg_cnt_first", avg_cnt - a0, 1);
        frame_settle(20'h00005, 20'h00010);
        chk("avg_5", avg_temp, 20'h00028);
        frame_settle(20'h00006, 20'h00090);
        chk("avg_6", avg_temp, 20'h00044);
        chk("avg_cnt_all", avg_cnt - a0, 3);

        // Alarm hysteresis: set, hold inside the band, clear below it.
        for (int i = 0; i < 4; i++) frame_settle(20'h0, 20'h80001);
        chk("alarm_avg_hi", avg_temp, 20'h80001);
        chk("alarm_set", temp_alarm, 1);
        for (int i = 0; i < 4; i++) frame_settle(20'h0, 20'h7FE00);
        chk("alarm_avg_band", avg_temp, 20'h7FE00);
        chk("alarm_hold", temp_alarm, 1);
        for (int i = 0; i < 3; i++) frame_settle(20'h0, 20'h7FBFF);
        chk("alarm_avg_edge", avg_temp, 20'h7FC7F);
        chk("alarm_hold_edge", temp_alarm, 1);
        frame_settle(20'h0, 20'h7FBFF);
        chk("alarm_avg_lo", avg_temp, 20'h7FBFF);
        chk("alarm_clear", temp_alarm, 0);
        for (int i = 0; i < 4; i++) frame_settle(20'h0, 20'hA0000);
        chk("alarm_reset_prep", temp_alarm, 1);

        // Asynchronous reset in the middle of a frame.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h04);
        reset = 1'b0;
        #1;
        chk("mid_rst_press", press_raw, 0);
        chk("mid_rst_temp", temp_raw, 0);
        chk("mid_rst_avg", avg_temp, 0);
        chk("mid_rst_flags", {frame_valid, avg_valid, temp_alarm, frame_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        a0 = avg_cnt;
        send_frame(20'hABCDE, 20'h00100);
        chk("post_rst_fv", frame_valid, 1);
        chk("post_rst_press", press_raw, 20'hABCDE);
        chk("post_rst_temp", temp_raw, 20'h00100);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        frame_settle(20'h0, 20'h00200);
        frame_settle(20'h0, 20'h00300);
        chk("post_rst_avg_quiet", avg_cnt - a0, 0);
        send_frame(20'h0, 20'h00400);
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_avg_valid", avg_valid, 1);
        chk("post_rst_avg", avg_temp, 20'h00280);
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_avg_cnt", avg_cnt - a0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
